ir_decode: RTL and testbench
============================

Name: ir_decode

Overview:
- Instruction register plus opcode decoder for the sm83 core; sits directly upstream of the control sequencer.
- Captures the fetched opcode byte when the sequencer asserts mem_to_ir.
- Tracks the 0xCB prefix state and drives ctl_op, alu_op and the register and bit selects that the sequencer and datapath consume.
- Keeps a sticky illegal-opcode flag and a retired-instruction counter for debug.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- RESET_IR, 8'h00, IR value after reset (NOP).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- mem_rdata  in  8  byte returned by the memory bus this cycle.
- mem_to_ir  in  1  sequencer strobe: capture mem_rdata into IR at this edge.
- halt  in  1  core halted; blocks IR capture and counting.
- ir  out  8  current instruction register.
- cb_active  out  1  IR holds the second byte of a CB-prefixed opcode.
- ctl_op  out  ctl_op_t  operation class for the sequencer.
- alu_op  out  alu_op_t  ALU function for the sequencer to pass through.
- r8_dst  out  3  destination r8 (B0 C1 D2 E3 H4 L5 (HL)6 A7).
- r8_src  out  3  source r8, same encoding.
- bit_idx  out  3  bit number for BIT, RES and SET.
- illegal  out  1  sticky: an unsupported opcode was decoded.
- instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- Reset, when rst is high at an edge:
  - ir = RESET_IR, cb_active = 0, illegal = 0, instr_count = 0.
  - Decode outputs then reflect NOP: ctl_op = CTL_NOP, alu_op = ALU_PASS, r8_dst = r8_src = bit_idx = 0.
  - Reset wins over mem_to_ir in the same cycle.
- Capture, at an edge with mem_to_ir = 1 and halt = 0:
  - ir takes mem_rdata.
  - cb_active takes (!cb_active && ir == 8'hCB). The prefix byte arms CB mode for exactly one capture; a CB opcode that is itself 0xCB decodes as a CB op and does not re-arm.
- Capture is blocked when mem_to_ir = 0 or halt = 1; ir and cb_active hold their values.
- Latency: decode outputs are combinational from the registered ir and cb_active, so they are valid the cycle after the capture edge. There is no mem_rdata-to-output combinational path.
- Unprefixed decode (cb_active = 0):
  - 0x00 -> CTL_NOP.
  - 0xCB -> CTL_PREFIX_CB.
  - 0x76 -> CTL_HALT.
  - 00ddd110 with ddd != 6 -> CTL_LD_R8_D8, r8_dst = ddd, alu_op = ALU_PASS.
  - 01dddsss:
    - sss == 6 -> CTL_LDPTR_R8_HL.
    - ddd == 6 -> CTL_LDPTR_HL_R8.
    - otherwise -> CTL_LD_R8_R8.
    - r8_dst = ddd, r8_src = sss, alu_op = ALU_PASS.
  - 10ooosss with sss != 6 -> CTL_ALU_R8, r8_dst = 7, r8_src = sss, alu_op from ooo: ADD ADC SUB SBC AND XOR OR CP.
  - 11ooo110 -> CTL_ALU_D8, r8_dst = 7, same ooo map.
  - Every other opcode -> CTL_ILLEGAL.
- CB decode (cb_active = 1), opcode pp xxx rrr:
  - rrr == 6 -> CTL_ILLEGAL. (HL) forms are not supported in this revision.
  - pp = 00 -> CTL_CB_R8, alu_op from xxx: RLC RRC RL RR SLA SRA SWAP SRL.
  - pp = 01 / 10 / 11 -> CTL_CB_R8 with alu_op ALU_BIT / ALU_RES / ALU_SET, bit_idx = xxx.
  - r8_dst = r8_src = rrr for all CB forms.
- illegal flag:
  - Set on any clock edge where ctl_op == CTL_ILLEGAL.
  - Cleared only by reset.
- instr_count:
  - Increments by 1 on every capture edge where the outgoing decode is not CTL_PREFIX_CB. A prefix plus its CB opcode counts as one instruction.
  - The first capture after reset counts the reset NOP.
  - Wraps from all-ones to 0.
- Simultaneous halt and mem_to_ir: halt wins, so there is no capture and no count.
- Reset while cb_active = 1 clears the prefix state; the next byte decodes unprefixed.

Decomposition:
- sm83_pkg additions:
  - ctl_op_t gains CTL_NOP, CTL_ALU_D8, CTL_PREFIX_CB, CTL_CB_R8, CTL_ILLEGAL.
  - alu_op_t gains ALU_PASS, the eight ooo ops, the eight CB shift ops, ALU_BIT, ALU_RES, ALU_SET.
  - New constants R8_HL_IND = 3'd6, R8_A = 3'd7, OPC_CB = 8'hCB, OPC_HALT = 8'h76.
- One natural sub-module: opcode_decode, a pure combinational function of (ir, cb_active) producing ctl_op, alu_op, r8_dst, r8_src and bit_idx. ir_decode keeps the registers and counters.

Test Plan:
- Reset -> ir = 0x00, ctl_op = CTL_NOP, instr_count = 0, illegal = 0; then capture 0x06 -> next cycle CTL_LD_R8_D8, r8_dst = 0, instr_count = 1.
- Capture 0x78 -> CTL_LD_R8_R8 with dst 7, src 0; 0x7E -> CTL_LDPTR_R8_HL; 0x77 -> CTL_LDPTR_HL_R8; 0x76 -> CTL_HALT (not an LD).
- Capture 0x91 -> CTL_ALU_R8, ALU_SUB, src 1; 0xFE -> CTL_ALU_D8, ALU_CP, dst 7.
- Capture 0xCB then 0x7C -> cb_active = 1, CTL_CB_R8, ALU_BIT, bit_idx 7, src 4, and instr_count +1 in total (not +2); then 0xCB, 0xCB -> CB op SET 1,E with cb_active = 0 after the next capture.
- Capture 0xD3 -> CTL_ILLEGAL and illegal = 1; a following 0x00 keeps illegal = 1 until rst.
- halt = 1 with mem_to_ir = 1 and mem_rdata = 0x3E -> ir unchanged, count unchanged; preload count to 0xFFFF, capture -> 0x0000.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 instruction register and decoder.
// ALU function helpers map opcode fields onto alu_op_t.
package sm83_pkg;

  typedef enum logic [3:0] {
    CTL_NOP,
    CTL_LD_R8_D8,
    CTL_LD_R8_R8,
    CTL_LDPTR_R8_HL,
    CTL_LDPTR_HL_R8,
    CTL_HALT,
    CTL_ALU_R8,
    CTL_ALU_D8,
    CTL_PREFIX_CB,
    CTL_CB_R8,
    CTL_ILLEGAL
  } ctl_op_t;

  typedef enum logic [4:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_ADC,
    ALU_SUB,
    ALU_SBC,
    ALU_AND,
    ALU_XOR,
    ALU_OR,
    ALU_CP,
    ALU_RLC,
    ALU_RRC,
    ALU_RL,
    ALU_RR,
    ALU_SLA,
    ALU_SRA,
    ALU_SWAP,
    ALU_SRL,
    ALU_BIT,
    ALU_RES,
    ALU_SET
  } alu_op_t;

  localparam logic [2:0] R8_HL_IND = 3'd6;
  localparam logic [2:0] R8_A      = 3'd7;
  localparam logic [7:0] OPC_NOP   = 8'h00;
  localparam logic [7:0] OPC_CB    = 8'hCB;
  localparam logic [7:0] OPC_HALT  = 8'h76;

  // Arithmetic/logic group selected by bits [5:3] of 10ooosss / 11ooo110.
  function automatic alu_op_t alu_from_ooo(input logic [2:0] ooo);
    alu_op_t op;
    case (ooo)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_ADC;
      3'd2:    op = ALU_SUB;
      3'd3:    op = ALU_SBC;
      3'd4:    op = ALU_AND;
      3'd5:    op = ALU_XOR;
      3'd6:    op = ALU_OR;
      default: op = ALU_CP;
    endcase
    return op;
  endfunction

  function automatic alu_op_t cb_shift_op(input logic [2:0] xxx);
    alu_op_t op;
    case (xxx)
      3'd0:    op = ALU_RLC;
      3'd1:    op = ALU_RRC;
      3'd2:    op = ALU_RL;
      3'd3:    op = ALU_RR;
      3'd4:    op = ALU_SLA;
      3'd5:    op = ALU_SRA;
      3'd6:    op = ALU_SWAP;
      default: op = ALU_SRL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/opcode_decode.sv
// Pure combinational opcode decoder: (ir, cb_active) -> operation class,
// ALU function and register/bit selects.
module opcode_decode
  import sm83_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       cb_active,
  output ctl_op_t    ctl_op,
  output alu_op_t    alu_op,
  output logic [2:0] r8_dst,
  output logic [2:0] r8_src,
  output logic [2:0] bit_idx
);

  logic [1:0] w_grp;
  logic [2:0] w_mid;
  logic [2:0] w_low;

  assign w_grp = ir[7:6];
  assign w_mid = ir[5:3];
  assign w_low = ir[2:0];

  always_comb begin
    ctl_op  = CTL_ILLEGAL;
    alu_op  = ALU_PASS;
    r8_dst  = 3'd0;
    r8_src  = 3'd0;
    bit_idx = 3'd0;

    if (cb_active) begin
      // CB forms with an (HL) operand decode as illegal.
      if (w_low != R8_HL_IND) begin
        ctl_op = CTL_CB_R8;
        r8_dst = w_low;
        r8_src = w_low;
        case (w_grp)
          2'b00: alu_op = cb_shift_op(w_mid);
          2'b01: begin alu_op = ALU_BIT; bit_idx = w_mid; end
          2'b10: begin alu_op = ALU_RES; bit_idx = w_mid; end
          default: begin alu_op = ALU_SET; bit_idx = w_mid; end
        endcase
      end
    end else if (ir == OPC_NOP) begin
      ctl_op = CTL_NOP;
    end else if (ir == OPC_CB) begin
      ctl_op = CTL_PREFIX_CB;
    end else if (ir == OPC_HALT) begin
      ctl_op = CTL_HALT;
    end else begin
      case (w_grp)
        2'b00: begin
          if (w_low == 3'd6 && w_mid != R8_HL_IND) begin
            ctl_op = CTL_LD_R8_D8;
            r8_dst = w_mid;
          end
        end
        2'b01: begin
          if (w_low == R8_HL_IND)      ctl_op = CTL_LDPTR_R8_HL;
          else if (w_mid == R8_HL_IND) ctl_op = CTL_LDPTR_HL_R8;
          else                         ctl_op = CTL_LD_R8_R8;
          r8_dst = w_mid;
          r8_src = w_low;
        end
        2'b10: begin
          if (w_low != R8_HL_IND) begin
            ctl_op = CTL_ALU_R8;
            alu_op = alu_from_ooo(w_mid);
            r8_dst = R8_A;
            r8_src = w_low;
          end
        end
        default: begin
          if (w_low == 3'd6) begin
            ctl_op = CTL_ALU_D8;
            alu_op = alu_from_ooo(w_mid);
            r8_dst = R8_A;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ir_decode.sv
// Instruction register with CB-prefix tracking, sticky illegal flag and a
// retired-instruction counter; decode itself lives in opcode_decode.
module ir_decode
  import sm83_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] RESET_IR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_to_ir,
  input  logic             halt,
  output logic [7:0]       ir,
  output logic             cb_active,
  output ctl_op_t          ctl_op,
  output alu_op_t          alu_op,
  output logic [2:0]       r8_dst,
  output logic [2:0]       r8_src,
  output logic [2:0]       bit_idx,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [7:0]       r_ir;
  logic             r_cb_active;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_capture;
  ctl_op_t          w_ctl_op;

  assign w_capture = mem_to_ir && !halt;

  opcode_decode u_opcode_decode (
    .ir        (r_ir),
    .cb_active (r_cb_active),
    .ctl_op    (w_ctl_op),
    .alu_op    (alu_op),
    .r8_dst    (r8_dst),
    .r8_src    (r8_src),
    .bit_idx   (bit_idx)
  );

  // The prefix byte counts together with its CB opcode as one instruction,
  // so the retiring decode is skipped when it is the prefix itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir          <= RESET_IR;
      r_cb_active   <= 1'b0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if (w_capture) begin
        r_ir        <= mem_rdata;
        r_cb_active <= !r_cb_active && (r_ir == OPC_CB);
        if (w_ctl_op != CTL_PREFIX_CB) begin
          r_instr_count <= r_instr_count + CNT_W'(1);
        end
      end
      if (w_ctl_op == CTL_ILLEGAL) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign ir          = r_ir;
  assign cb_active   = r_cb_active;
  assign ctl_op      = w_ctl_op;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_ir_decode.sv
// Directed self-checking bench for ir_decode with hand-computed expectations.
module tb_ir_decode;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_to_ir = 1'b0;
  logic        halt = 1'b0;
  logic [7:0]  ir;
  logic        cb_active;
  ctl_op_t     ctl_op;
  alu_op_t     alu_op;
  logic [2:0]  r8_dst;
  logic [2:0]  r8_src;
  logic [2:0]  bit_idx;
  logic        illegal;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  ir_decode #(.CNT_W(16), .RESET_IR(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rdata   (mem_rdata),
    .mem_to_ir   (mem_to_ir),
    .halt        (halt),
    .ir          (ir),
    .cb_active   (cb_active),
    .ctl_op      (ctl_op),
    .alu_op      (alu_op),
    .r8_dst      (r8_dst),
    .r8_src      (r8_src),
    .bit_idx     (bit_idx),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic strobe,
                               input logic h, input logic r);
    @(negedge clk);
    mem_rdata = data;
    mem_to_ir = strobe;
    halt      = h;
    rst       = r;
    @(posedge clk);
    #1;
    mem_to_ir = 1'b0;
    halt      = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_ir", 32'(ir), 32'h00);
    checkOutput("rst_ctl", 32'(ctl_op), 32'(CTL_NOP));
    checkOutput("rst_alu", 32'(alu_op), 32'(ALU_PASS));
    checkOutput("rst_cnt", 32'(instr_count), 32'd0);
    checkOutput("rst_ill", 32'(illegal), 32'd0);
    checkOutput("rst_cb", 32'(cb_active), 32'd0);

    // LD B,d8
    applyStimulus(8'h06, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_d8_ctl", 32'(ctl_op), 32'(CTL_LD_R8_D8));
    checkOutput("ld_d8_dst", 32'(r8_dst), 32'd0);
    checkOutput("ld_d8_cnt", 32'(instr_count), 32'd1);

    // LD A,B
    applyStimulus(8'h78, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_rr_ctl", 32'(ctl_op), 32'(CTL_LD_R8_R8));
    checkOutput("ld_rr_dst", 32'(r8_dst), 32'd7);
    checkOutput("ld_rr_src", 32'(r8_src), 32'd0);

    // LD A,(HL)
    applyStimulus(8'h7E, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_r_hl_ctl", 32'(ctl_op), 32'(CTL_LDPTR_R8_HL));
    checkOutput("ld_r_hl_dst", 32'(r8_dst), 32'd7);

    // LD (HL),A
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b0);
    checkOutput("ld_hl_r_ctl", 32'(ctl_op), 32'(CTL_LDPTR_HL_R8));
    checkOutput("ld_hl_r_src", 32'(r8_src), 32'd7);

    // HALT
    applyStimulus(8'h76, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_ctl", 32'(ctl_op), 32'(CTL_HALT));
    checkOutput("halt_cnt", 32'(instr_count), 32'd5);

    // SUB C
    applyStimulus(8'h91, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_ctl", 32'(ctl_op), 32'(CTL_ALU_R8));
    checkOutput("sub_alu", 32'(alu_op), 32'(ALU_SUB));
    checkOutput("sub_src", 32'(r8_src), 32'd1);
    checkOutput("sub_dst", 32'(r8_dst), 32'd7);

    // CP d8
    applyStimulus(8'hFE, 1'b1, 1'b0, 1'b0);
    checkOutput("cp_ctl", 32'(ctl_op), 32'(CTL_ALU_D8));
    checkOutput("cp_alu", 32'(alu_op), 32'(ALU_CP));
    checkOutput("cp_dst", 32'(r8_dst), 32'd7);
    checkOutput("cp_cnt", 32'(instr_count), 32'd7);

    // CB prefix then BIT 7,H
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    checkOutput("pfx_ctl", 32'(ctl_op), 32'(CTL_PREFIX_CB));
    checkOutput("pfx_cb", 32'(cb_active), 32'd0);
    applyStimulus(8'h7C, 1'b1, 1'b0, 1'b0);
    checkOutput("bit_cb", 32'(cb_active), 32'd1);
    checkOutput("bit_ctl", 32'(ctl_op), 32'(CTL_CB_R8));
    checkOutput("bit_alu", 32'(alu_op), 32'(ALU_BIT));
    checkOutput("bit_idx", 32'(bit_idx), 32'd7);
    checkOutput("bit_src", 32'(r8_src), 32'd4);
    checkOutput("bit_cnt", 32'(instr_count), 32'd8);

    // CB CB = SET 1,E; the second CB must not re-arm the prefix
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    checkOutput("cbcb1_cb", 32'(cb_active), 32'd0);
    checkOutput("cbcb1_ctl", 32'(ctl_op), 32'(CTL_PREFIX_CB));
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    checkOutput("set_cb", 32'(cb_active), 32'd1);
    checkOutput("set_ctl", 32'(ctl_op), 32'(CTL_CB_R8));
    checkOutput("set_alu", 32'(alu_op), 32'(ALU_SET));
    checkOutput("set_idx", 32'(bit_idx), 32'd1);
    checkOutput("set_dst", 32'(r8_dst), 32'd3);
    checkOutput("set_cnt", 32'(instr_count), 32'd9);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("after_set_cb", 32'(cb_active), 32'd0);
    checkOutput("after_set_ctl", 32'(ctl_op), 32'(CTL_NOP));
    checkOutput("after_set_cnt", 32'(instr_count), 32'd10);

    // Reset with an armed prefix and a simultaneous capture
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1);
    checkOutput("rstcb_ir", 32'(ir), 32'h00);
    checkOutput("rstcb_cb", 32'(cb_active), 32'd0);
    checkOutput("rstcb_cnt", 32'(instr_count), 32'd0);
    applyStimulus(8'h7C, 1'b1, 1'b0, 1'b0);
    checkOutput("rstcb_ld_ctl", 32'(ctl_op), 32'(CTL_LD_R8_R8));
    checkOutput("rstcb_ld_src", 32'(r8_src), 32'd4);
    checkOutput("rstcb_ld_cnt", 32'(instr_count), 32'd1);

    // Illegal opcode and sticky flag
    applyStimulus(8'hD3, 1'b1, 1'b0, 1'b0);
    checkOutput("ill_ctl", 32'(ctl_op), 32'(CTL_ILLEGAL));
    checkOutput("ill_flag_pre", 32'(illegal), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("ill_flag", 32'(illegal), 32'd1);
    checkOutput("ill_nop_ctl", 32'(ctl_op), 32'(CTL_NOP));
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ill_sticky", 32'(illegal), 32'd1);
    checkOutput("ill_cnt", 32'(instr_count), 32'd3);

    // Halt blocks capture, and so does a missing strobe
    applyStimulus(8'h3E, 1'b1, 1'b1, 1'b0);
    checkOutput("halt_ir", 32'(ir), 32'h00);
    checkOutput("halt_hold_cnt", 32'(instr_count), 32'd3);
    applyStimulus(8'h3E, 1'b0, 1'b0, 1'b0);
    checkOutput("nostrobe_ir", 32'(ir), 32'h00);

    // CB (HL) form traps; CB SRL A decodes
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h46, 1'b1, 1'b0, 1'b0);
    checkOutput("cbhl_ctl", 32'(ctl_op), 32'(CTL_ILLEGAL));
    checkOutput("cbhl_cnt", 32'(instr_count), 32'd4);
    applyStimulus(8'hCB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h3F, 1'b1, 1'b0, 1'b0);
    checkOutput("srl_ctl", 32'(ctl_op), 32'(CTL_CB_R8));
    checkOutput("srl_alu", 32'(alu_op), 32'(ALU_SRL));
    checkOutput("srl_dst", 32'(r8_dst), 32'd7);
    checkOutput("srl_cnt", 32'(instr_count), 32'd5);

    // Reset clears the sticky flag, then count up to all-ones and wrap
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("rst2_ill", 32'(illegal), 32'd0);
    @(negedge clk);
    mem_rdata = 8'h00;
    mem_to_ir = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    mem_to_ir = 1'b0;
    checkOutput("cnt_max", 32'(instr_count), 32'hFFFF);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("cnt_wrap", 32'(instr_count), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
